// File: rtl/vector_addsub_pipe_pkg.sv
// Shared constants for the vector add/subtract unit:
// instruction bit positions, default sizes, vector-length rule.
package vector_addsub_pipe_pkg;

  localparam int INSTR_VEC = 0;
  localparam int INSTR_SUB = 1;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_NVREG = 8;
  localparam int DEF_VL_W  = 7;
  localparam int DEF_LAT   = 2;

  // A zero length field selects the maximum element count.
  function automatic int vl_len(input int vl, input int vl_w);
    return (vl == 0) ? (1 << (vl_w - 1)) : vl;
  endfunction

endpackage

// File: rtl/vector_addsub_lane.sv
// Combinational add/subtract of one element, with the carry
// chain broken at the half-word boundary in packed mode.
module vector_addsub_lane
  import vector_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             packed_mode,
  output logic [WIDTH-1:0] y
);

  localparam int H = WIDTH / 2;

  logic [WIDTH-1:0] bx;
  logic [H:0]       lo;
  logic [H-1:0]     hi;
  logic             hi_cin;

  // Subtract is a + ~b + 1; packed lanes each take their own +1.
  always_comb begin
    bx     = sub ? ~b : b;
    lo     = {1'b0, a[H-1:0]} + {1'b0, bx[H-1:0]}
           + {{H{1'b0}}, sub};
    hi_cin = packed_mode ? sub : lo[H];
    hi     = a[WIDTH-1:H] + bx[WIDTH-1:H]
           + {{(H-1){1'b0}}, hi_cin};
    y      = {hi, lo[H-1:0]};
  end

endmodule

// File: rtl/vector_addsub_pipe.sv
// Vector integer add/subtract unit: element sequencer,
// operand capture and a fixed-latency result pipeline.
module vector_addsub_pipe
  import vector_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NVREG = DEF_NVREG,
  parameter int VL_W  = DEF_VL_W,
  parameter int LAT   = DEF_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [1:0]                 i_instr,
  input  logic                       i_packed,
  input  logic [VL_W-1:0]            i_vl,
  input  logic [WIDTH-1:0]           i_sj,
  input  logic [$clog2(NVREG)-1:0]   i_i,
  input  logic [$clog2(NVREG)-1:0]   i_j,
  input  logic [$clog2(NVREG)-1:0]   i_k,
  input  logic [NVREG*WIDTH-1:0]     i_vregs,
  output logic [WIDTH-1:0]           o_result,
  output logic                       o_valid,
  output logic [VL_W-2:0]            o_elem,
  output logic [$clog2(NVREG)-1:0]   o_dest,
  output logic                       o_busy,
  output logic                       o_reject
);

  localparam int RW = $clog2(NVREG);
  localparam int EW = VL_W - 1;
  localparam int NS = LAT - 1;

  logic [WIDTH-1:0] vreg [NVREG];

  for (genvar r = 0; r < NVREG; r++) begin : g_vr
    assign vreg[r] = i_vregs[r*WIDTH +: WIDTH];
  end

  logic [1:0]       instr_q;
  logic             pk_q;
  logic [WIDTH-1:0] sj_q;
  logic [RW-1:0]    i_q;
  logic [RW-1:0]    j_q;
  logic [RW-1:0]    k_q;
  logic [VL_W-1:0]  n_q;
  logic [VL_W-1:0]  cnt;
  logic [VL_W-1:0]  n_in;
  logic             issue;
  logic             cap_en;

  logic [1:0]       ins_sel;
  logic             pk_sel;
  logic [WIDTH-1:0] sj_sel;
  logic [RW-1:0]    dst_sel;
  logic [RW-1:0]    j_sel;
  logic [RW-1:0]    k_sel;
  logic [EW-1:0]    elem_sel;

  assign issue  = i_start & ~o_busy;
  assign cap_en = issue | o_busy;
  assign n_in   = VL_W'(vl_len(int'(i_vl), VL_W));

  // Element 0 reads the live selects; later elements the latched ones.
  always_comb begin
    ins_sel  = issue ? i_instr  : instr_q;
    pk_sel   = issue ? i_packed : pk_q;
    sj_sel   = issue ? i_sj     : sj_q;
    dst_sel  = issue ? i_i      : i_q;
    j_sel    = issue ? i_j      : j_q;
    k_sel    = issue ? i_k      : k_q;
    elem_sel = issue ? '0       : cnt[EW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_busy   <= 1'b0;
      o_reject <= 1'b0;
      cnt      <= '0;
      n_q      <= '0;
      instr_q  <= '0;
      pk_q     <= 1'b0;
      sj_q     <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
    end else begin
      o_reject <= i_start & o_busy;
      if (issue) begin
        instr_q <= i_instr;
        pk_q    <= i_packed;
        sj_q    <= i_sj;
        i_q     <= i_i;
        j_q     <= i_j;
        k_q     <= i_k;
        n_q     <= n_in;
        cnt     <= VL_W'(1);
        o_busy  <= (n_in != VL_W'(1));
      end else if (o_busy) begin
        cnt <= cnt + VL_W'(1);
        if (cnt == n_q - VL_W'(1))
          o_busy <= 1'b0;
      end
    end
  end

  logic             cap_v;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic             cap_sub;
  logic             cap_pk;
  logic [EW-1:0]    cap_e;
  logic [RW-1:0]    cap_dst;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_v   <= 1'b0;
      cap_a   <= '0;
      cap_b   <= '0;
      cap_sub <= 1'b0;
      cap_pk  <= 1'b0;
      cap_e   <= '0;
      cap_dst <= '0;
    end else begin
      cap_v <= cap_en;
      if (cap_en) begin
        cap_a   <= ins_sel[INSTR_VEC] ? vreg[j_sel] : sj_sel;
        cap_b   <= vreg[k_sel];
        cap_sub <= ins_sel[INSTR_SUB];
        cap_pk  <= pk_sel;
        cap_e   <= elem_sel;
        cap_dst <= dst_sel;
      end
    end
  end

  logic [WIDTH-1:0] lane_y;

  vector_addsub_lane #(
    .WIDTH(WIDTH)
  ) u_lane (
    .a          (cap_a),
    .b          (cap_b),
    .sub        (cap_sub),
    .packed_mode(cap_pk),
    .y          (lane_y)
  );

  logic             st_v   [NS];
  logic [WIDTH-1:0] st_d   [NS];
  logic [EW-1:0]    st_e   [NS];
  logic [RW-1:0]    st_dst [NS];

  // Payload only moves with a valid, so idle outputs hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        st_v[s]   <= 1'b0;
        st_d[s]   <= '0;
        st_e[s]   <= '0;
        st_dst[s] <= '0;
      end
    end else begin
      st_v[0] <= cap_v;
      if (cap_v) begin
        st_d[0]   <= lane_y;
        st_e[0]   <= cap_e;
        st_dst[0] <= cap_dst;
      end
      for (int s = 1; s < NS; s++) begin
        st_v[s] <= st_v[s-1];
        if (st_v[s-1]) begin
          st_d[s]   <= st_d[s-1];
          st_e[s]   <= st_e[s-1];
          st_dst[s] <= st_dst[s-1];
        end
      end
    end
  end

  assign o_valid  = st_v[NS-1];
  assign o_result = st_d[NS-1];
  assign o_elem   = st_e[NS-1];
  assign o_dest   = st_dst[NS-1];

endmodule
